// File: rtl/sseg_status_display.sv
// sseg_status_display: run-status tracker and cycle counter that renders character codes for
// eight seven-segment digit decoders.
module sseg_status_display #(
    parameter int PAGE_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        done,
    input  logic        blank,
    output logic [39:0] digit_codes,
    output logic [31:0] cycle_count,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int TW = PAGE_CYCLES > 1 ? $clog2(PAGE_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(PAGE_CYCLES - 1);
    state_t state;
    logic page;
    logic [TW-1:0] page_timer;
    logic [39:0] hex_all, next_codes;
    always_comb begin
        hex_all = '0;
        for (int i = 0; i < 8; i++) hex_all[5*i +: 5] = {1'b0, cycle_count[4*i +: 4]};
        next_codes = blank ? {8{5'd27}} :
                     state == RUN ? {5'd22, 5'd25, 5'd19, 5'd27, hex_all[39:20]} :
                     state == DONE ? (page ? hex_all : {5'd13, 5'd20, 5'd19, 5'd14, {4{5'd27}}}) :
                     {5'd27, 5'd27, 5'd27, 5'd22, 5'd14, 5'd10, 5'd13, 5'd26};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cycle_count <= '0;
            page <= 1'b0;
            page_timer <= '0;
            busy <= 1'b0;
            digit_codes <= {8{5'd27}};
        end else begin
            digit_codes <= next_codes;
            busy <= state == RUN;
            if (state == RUN) begin
                if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
                if (done) begin
                    state <= DONE;
                    page <= 1'b0;
                    page_timer <= '0;
                end
            end else if (start) begin
                state <= RUN;
                cycle_count <= '0;
            end else if (state == DONE) begin
                // the page flips on the same edge the timer wraps
                page_timer <= page_timer == LAST ? '0 : page_timer + 1'b1;
                if (page_timer == LAST) page <= ~page;
            end
        end
    end
endmodule

// File: tb/tb_sseg_status_display.sv
// tb_sseg_status_display: table-driven vectors plus a reference model feeding a scoreboard queue.
module tb_sseg_status_display;
    localparam int PC = 4;
    logic clk = 0, rst = 1, start = 0, done = 0, blank = 0;
    logic [39:0] digit_codes;
    logic [31:0] cycle_count;
    logic busy;
    int checks = 0, errors = 0;

    sseg_status_display #(.PAGE_CYCLES(PC)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .blank(blank),
        .digit_codes(digit_codes), .cycle_count(cycle_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [39:0] dig; logic [31:0] cnt; logic busy;} exp_t;
    typedef struct {bit r, s, d, b; exp_t e;} vec_t;
    exp_t q[$];
    vec_t tab[23];

    int m_state = 0, m_timer = 0;
    bit m_page = 0, m_busy = 0;
    logic [31:0] m_cnt = 0;
    logic [39:0] m_dig = 0;

    function automatic logic [39:0] pk(input int a7, a6, a5, a4, a3, a2, a1, a0);
        return {a7[4:0], a6[4:0], a5[4:0], a4[4:0], a3[4:0], a2[4:0], a1[4:0], a0[4:0]};
    endfunction

    function automatic logic [39:0] render(input int st, input bit pg, input logic [31:0] c);
        int n[8];
        for (int i = 0; i < 8; i++) n[i] = int'(c[4*i +: 4]);
        if (st == 1) return pk(22, 25, 19, 27, n[7], n[6], n[5], n[4]);
        if (st == 2) return pg ? pk(n[7], n[6], n[5], n[4], n[3], n[2], n[1], n[0])
                               : pk(13, 20, 19, 14, 27, 27, 27, 27);
        return pk(27, 27, 27, 22, 14, 10, 13, 26);
    endfunction

    task automatic model_step(input bit r, s, d, b);
        if (r) begin
            m_state = 0; m_cnt = 0; m_page = 0; m_timer = 0; m_busy = 0;
            m_dig = pk(27, 27, 27, 27, 27, 27, 27, 27);
            return;
        end
        m_dig = b ? pk(27, 27, 27, 27, 27, 27, 27, 27) : render(m_state, m_page, m_cnt);
        m_busy = m_state == 1;
        if (m_state == 1) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (d) begin m_state = 2; m_page = 0; m_timer = 0; end
        end else if (s) begin
            m_state = 1; m_cnt = 0;
        end else if (m_state == 2) begin
            if (m_timer == PC - 1) begin m_timer = 0; m_page = !m_page; end
            else m_timer++;
        end
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic score();
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
            return;
        end
        checks--;
        e = q.pop_front();
        check("digit_codes", digit_codes, e.dig);
        check("cycle_count", 40'(cycle_count), 40'(e.cnt));
        check("busy", 40'(busy), 40'(e.busy));
    endtask

    task automatic cyc(input bit r, s, d, b, input bit use_tab, input exp_t te);
        @(negedge clk);
        rst = r; start = s; done = d; blank = b;
        model_step(r, s, d, b);
        q.push_back(use_tab ? te : exp_t'{m_dig, m_cnt, m_busy});
        @(posedge clk);
        #1 score();
    endtask

    task automatic run(input bit r, s, d, b, input int n);
        exp_t z = '{0, 0, 0};
        for (int i = 0; i < n; i++) cyc(r, s, d, b, 0, z);
    endtask

    initial begin
        logic [39:0] off_d, idle_d, run0, done0, hexa;
        off_d = pk(27, 27, 27, 27, 27, 27, 27, 27);
        idle_d = pk(27, 27, 27, 22, 14, 10, 13, 26);
        run0 = pk(22, 25, 19, 27, 0, 0, 0, 0);
        done0 = pk(13, 20, 19, 14, 27, 27, 27, 27);
        hexa = pk(0, 0, 0, 0, 0, 0, 0, 10);
        for (int i = 0; i < 23; i++) tab[i] = '{0, 0, 0, 0, '{done0, 10, 0}};
        tab[0] = '{1, 0, 0, 0, '{off_d, 0, 0}};
        tab[1] = tab[0];
        tab[2] = '{0, 0, 0, 0, '{idle_d, 0, 0}};
        tab[3] = '{0, 1, 0, 0, '{idle_d, 0, 0}};
        for (int i = 4; i <= 12; i++) tab[i] = '{0, 0, 0, 0, '{run0, 32'(i - 3), 1}};
        tab[13] = '{0, 0, 1, 0, '{run0, 10, 1}};
        for (int i = 18; i <= 21; i++) tab[i].e.dig = hexa;

        for (int i = 0; i < 23; i++) cyc(tab[i].r, tab[i].s, tab[i].d, tab[i].b, 1, tab[i].e);

        run(0, 0, 0, 1, 3);          // blanked while paging continues
        run(0, 0, 1, 0, 7);          // done ignored in DONE
        run(0, 1, 0, 0, 1);          // restart from DONE
        run(0, 0, 0, 0, 5);
        run(0, 1, 0, 0, 1);          // start mid-RUN must not clear
        run(0, 0, 0, 0, 3);
        run(1, 0, 0, 0, 1);          // reset mid-RUN
        run(0, 0, 0, 0, 2);
        run(0, 0, 1, 0, 2);          // done in IDLE ignored
        run(0, 1, 1, 0, 1);          // start+done together in IDLE
        run(0, 0, 0, 0, 3);

        force dut.cycle_count = 32'hFFFF_FFFE;
        #1 release dut.cycle_count;
        m_cnt = 32'hFFFF_FFFE;
        run(0, 0, 0, 0, 5);
        check("sat_count", 40'(cycle_count), 40'(32'hFFFF_FFFF));
        check("sat_digits", 40'(digit_codes[19:0]), 40'({4{5'd15}}));
        run(0, 0, 1, 0, 1);
        run(0, 0, 0, 0, 9);          // page1 shows all F
        run(0, 1, 0, 0, 2);
        run(1, 0, 0, 0, 2);
        run(0, 0, 0, 0, 2);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
